mpu_sequencer: RTL
==================

// Module: mpu_sequencer
// PURPOSE
//  Fetch/issue controller for the MPU program counter (mpu_counter). Drives the counter's
//  en/incr/load/data controls, fetches instructions from imem at the current PC, hands each
//  instruction to the execute stage, then advances the PC, jumps or halts according to the
//  execute result. Sits between mpu_counter, the instruction memory port and the MPU execute unit.
// PARAMETERS
//  INS_BYTES      4    PC increment per sequential instruction (driven on pc_incr)
//  FETCH_TIMEOUT  255  max cycles FETCH waits for imem_ack before fault; 8-bit counter
// PORTS
//  sys_clk     in   1   clock; all logic on rising edge
//  sys_rst     in   1   asynchronous active-high reset
//  start       in   1   pulse: begin execution at start_adr (honoured only in IDLE/HALT)
//  start_adr   in   16  first instruction address
//  halted      out  1   1 in IDLE/HALT
//  fault       out  1   sticky fetch-timeout flag; cleared by start or reset
//  pc_en       out  1   to mpu_counter.en: out <= out + incr on next edge
//  pc_incr     out  16  to mpu_counter.incr (constant INS_BYTES)
//  pc_load     out  1   to mpu_counter.load: out <= data on next edge
//  pc_data     out  16  to mpu_counter.data
//  pc          in   16  from mpu_counter.out
//  imem_req    out  1   fetch request, held until imem_ack
//  imem_adr    out  16  fetch address (= pc)
//  imem_ack    in   1   fetch complete; imem_dat valid this cycle
//  imem_dat    in   32  fetched instruction
//  ins_valid   out  1   instruction valid to execute
//  ins         out  32  registered instruction
//  ins_ready   in   1   execute accepts ins (transfer = ins_valid & ins_ready)
//  exe_done    in   1   execute finished current instruction (one-cycle pulse)
//  exe_jmp     in   1   with exe_done: load PC with exe_target
//  exe_target  in   16  jump destination
//  exe_halt    in   1   with exe_done: stop execution
// BEHAVIOUR
//  - Reset (async): state IDLE; halted=1; fault=0; pc_en=pc_load=imem_req=ins_valid=0;
//    pc_data=0; ins=0; timeout counter=0. imem_req drops immediately even mid-fetch.
//  - pc_incr = INS_BYTES at all times. pc_en and pc_load are never asserted in the same cycle
//    and are single-cycle pulses; each is asserted on the cycle the FSM enters FETCH, so pc is
//    already updated when FETCH drives imem_adr.
//  - IDLE/HALT: on start -> pc_load=1, pc_data=start_adr, fault<=0, go FETCH. Other inputs ignored.
//  - FETCH: imem_req=1, imem_adr=pc, timer++ per cycle. On imem_ack: ins<=imem_dat, timer<=0,
//    go ISSUE (ack on the first FETCH cycle is legal: 1-cycle fetch). If timer reaches
//    FETCH_TIMEOUT with no ack: imem_req<=0, fault<=1, go HALT. Ack and timeout in the same
//    cycle: ack wins.
//  - ISSUE: ins_valid=1, ins stable until ins_ready; on transfer go WAIT_EXEC.
//  - WAIT_EXEC: wait exe_done. Priority exe_halt > exe_jmp > sequential:
//    halt -> HALT (no PC change); jmp -> pc_load=1, pc_data=exe_target, go FETCH;
//    else -> pc_en=1, go FETCH. exe_done outside WAIT_EXEC is ignored.
//  - Latency: start -> imem_req 1 cycle; exe_done -> next imem_req 1 cycle.
//  - PC arithmetic is 16-bit modulo: 0xFFFC + 4 -> 0x0000, no fault.
//  - start while running (FETCH/ISSUE/WAIT_EXEC) is ignored.
//  - Reset mid-operation: FSM returns to IDLE; mpu_counter shares sys_rst and returns to 0.
// STRUCTURE
//  - mpu_pkg: state encoding (IDLE, FETCH, ISSUE, WAIT_EXEC, HALT), default INS_BYTES,
//    MPU address/instruction width constants.
//  - One sub-module: mpu_fetch_timer (clear/count/expire, width from FETCH_TIMEOUT).
//  - FSM, ins register and PC control decode in this module; mpu_counter instantiated
//    by the parent.
// TESTING (bench instantiates mpu_sequencer + mpu_counter + imem model + execute model)
//  1. start, start_adr=0x0100, 1-cycle ack -> pc=0x0100, imem_adr=0x0100, halted=0 next cycle.
//  2. 3 sequential exe_done -> fetch addresses 0x0100,0x0104,0x0108,0x010C, one pc_en each.
//  3. exe_done+exe_jmp, exe_target=0x0040 -> pc_load pulse, next imem_adr=0x0040.
//  4. exe_done+exe_jmp+exe_halt -> HALT, halted=1, pc unchanged, no imem_req.
//  5. imem_ack withheld -> after 255 FETCH cycles fault=1, halted=1; start clears fault.
//  6. sys_rst mid-FETCH -> imem_req=0 immediately, IDLE, pc=0; start_adr=0xFFFC + done -> pc=0x0000.

Source files
------------

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared constants and FSM state encoding for the MPU fetch/issue
// sequencer.
//   ADR_W              MPU address (PC) width
//   INS_W              instruction width
//   INS_BYTES_DEF      default PC step per sequential instruction
//   FETCH_TIMEOUT_DEF  default fetch wait limit in cycles
package mpu_pkg;

    localparam int ADR_W             = 16;
    localparam int INS_W             = 32;
    localparam int INS_BYTES_DEF     = 4;
    localparam int FETCH_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_EXEC = 3'd3,
        ST_HALT      = 3'd4
    } mpu_state_e;

endpackage

// File: rtl/mpu_fetch_timer.sv
// mpu_fetch_timer: cycle counter that bounds how long a fetch may wait.
//   sys_clk  in   clock
//   sys_rst  in   asynchronous active-high reset
//   clr      in   return the count to zero (wins over cnt)
//   cnt      in   count one cycle
//   expire   out  high on the counting cycle that brings the count to LIMIT
module mpu_fetch_timer #(
    parameter int LIMIT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic cnt,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (cnt)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // The count starts at zero on the first waiting cycle, so the LIMIT-th
    // waiting cycle is the one that sees LIMIT-1.
    assign expire = cnt && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/mpu_sequencer.sv
// mpu_sequencer: fetch/issue controller for the MPU program counter.
// Drives the external PC counter, fetches from imem at pc, hands the
// instruction to execute, then steps, jumps or halts on the execute result.
//   sys_clk, sys_rst           clock, async active-high reset
//   start, start_adr           begin execution (honoured in IDLE/HALT)
//   halted, fault              status; fault is a sticky fetch timeout
//   pc_en/pc_incr/pc_load/pc_data  counter controls; pc is the counter value
//   imem_req/imem_adr/imem_ack/imem_dat  instruction fetch port
//   ins_valid/ins/ins_ready    instruction handoff to execute
//   exe_done/exe_jmp/exe_target/exe_halt  execute completion result
module mpu_sequencer
    import mpu_pkg::*;
#(
    parameter int INS_BYTES     = INS_BYTES_DEF,
    parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [ADR_W-1:0] start_adr,
    output logic             halted,
    output logic             fault,
    output logic             pc_en,
    output logic [ADR_W-1:0] pc_incr,
    output logic             pc_load,
    output logic [ADR_W-1:0] pc_data,
    input  logic [ADR_W-1:0] pc,
    output logic             imem_req,
    output logic [ADR_W-1:0] imem_adr,
    input  logic             imem_ack,
    input  logic [INS_W-1:0] imem_dat,
    output logic             ins_valid,
    output logic [INS_W-1:0] ins,
    input  logic             ins_ready,
    input  logic             exe_done,
    input  logic             exe_jmp,
    input  logic [ADR_W-1:0] exe_target,
    input  logic             exe_halt
);

    mpu_state_e       state_q, state_d;
    logic             fault_q, fault_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic             in_fetch;
    logic             tmr_expire;

    assign in_fetch = (state_q == ST_FETCH);

    mpu_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (!in_fetch || imem_ack),
        .cnt     (in_fetch),
        .expire  (tmr_expire)
    );

    // pc_en/pc_load are decoded in the cycle that transitions into FETCH, so
    // the counter updates on that same edge and pc is correct on the first
    // FETCH cycle.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ins_d   = ins_q;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        pc_data = '0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_load = 1'b1;
                    pc_data = start_adr;
                    fault_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // ack wins over a simultaneous timeout
                if (imem_ack) begin
                    ins_d   = imem_dat;
                    state_d = ST_ISSUE;
                end else if (tmr_expire) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_ISSUE: begin
                if (ins_ready)
                    state_d = ST_WAIT_EXEC;
            end
            ST_WAIT_EXEC: begin
                if (exe_done) begin
                    if (exe_halt) begin
                        state_d = ST_HALT;
                    end else if (exe_jmp) begin
                        pc_load = 1'b1;
                        pc_data = exe_target;
                        state_d = ST_FETCH;
                    end else begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            ins_q   <= ins_d;
        end
    end

    // Request decoded from state so reset drops it without waiting for a clock.
    assign imem_req  = in_fetch;
    assign imem_adr  = pc;
    assign ins_valid = (state_q == ST_ISSUE);
    assign ins       = ins_q;
    assign halted    = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign fault     = fault_q;
    assign pc_incr   = ADR_W'(INS_BYTES);

endmodule
